// File: rtl/uart_bus_if.sv
// CPU-side memory bus for the UART peripheral.
// One outstanding access; mem_ready completes it.
interface uart_bus_if;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid,
        output mem_addr,
        output mem_wdata,
        output mem_wstrb,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_valid,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wstrb,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/uart_controller.sv
// Memory-mapped UART peripheral: TX/RX byte FIFOs between
// the CPU bus and a pulse-driven uart core.
module uart_controller #(
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    uart_bus_if.slave  bus,
    output logic       tx_trigger,
    output logic [7:0] tx_byte,
    input  logic       received,
    input  logic [7:0] rx_byte,
    input  logic       is_transmitting,
    input  logic       recv_error
);
    localparam int TW = $clog2(TX_DEPTH);
    localparam int RW = $clog2(RX_DEPTH);

    typedef enum logic {B_IDLE, B_RESP} bus_st_t;
    typedef enum logic [2:0] {
        T_IDLE, T_START, T_TRIG, T_WBUSY, T_WDONE
    } tx_st_t;

    bus_st_t bus_st;
    tx_st_t  tx_st;

    logic [7:0] tx_mem [TX_DEPTH];
    logic [7:0] rx_mem [RX_DEPTH];
    logic [TW:0] tx_wp, tx_rp;
    logic [RW:0] rx_wp, rx_rp;
    logic rx_overrun, rx_error;

    logic tx_full, tx_empty, rx_full, rx_empty;
    logic acc, is_wr, is_ctrl;
    logic rd_data, rd_stat, wr_data, wr_ctrl;
    logic tx_push, rx_pop, accept;
    logic rx_push, set_ovr;
    logic [31:0] status, rdata_nxt;

    logic unused_bits;
    assign unused_bits = ^{bus.mem_addr[31:3], bus.mem_addr[1:0],
                           bus.mem_wdata[31:8]};

    // Full when pointers differ only in the wrap bit.
    assign tx_full  = (tx_wp ^ tx_rp) == {1'b1, {TW{1'b0}}};
    assign tx_empty = tx_wp == tx_rp;
    assign rx_full  = (rx_wp ^ rx_rp) == {1'b1, {RW{1'b0}}};
    assign rx_empty = rx_wp == rx_rp;

    assign acc     = (bus_st == B_IDLE) && bus.mem_valid;
    assign is_wr   = |bus.mem_wstrb;
    assign is_ctrl = bus.mem_addr[2];
    assign rd_data = acc && !is_wr && !is_ctrl;
    assign rd_stat = acc && !is_wr && is_ctrl;
    assign wr_data = acc && is_wr && !is_ctrl;
    assign wr_ctrl = acc && is_wr && is_ctrl;

    assign tx_push = wr_data && !tx_full;
    assign rx_pop  = rd_data && !rx_empty;
    assign accept  = acc && !(wr_data && tx_full);

    assign rx_push = received && !recv_error && (!rx_full || rx_pop);
    assign set_ovr = received && !recv_error && rx_full && !rx_pop;

    assign status = {26'd0, is_transmitting, rx_error, rx_overrun,
                     !rx_empty, tx_empty, tx_full};

    always_comb begin
        rdata_nxt = 32'd0;
        unique case (1'b1)
            rd_data: rdata_nxt = rx_empty ? 32'hFFFF_FFFF
                                          : {24'd0, rx_mem[rx_rp[RW-1:0]]};
            rd_stat: rdata_nxt = status;
            default: rdata_nxt = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (tx_push)
            tx_mem[tx_wp[TW-1:0]] <= bus.mem_wdata[7:0];
        if (rx_push)
            rx_mem[rx_wp[RW-1:0]] <= rx_byte;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus_st        <= B_IDLE;
            bus.mem_ready <= 1'b0;
            bus.mem_rdata <= 32'd0;
            tx_wp         <= '0;
            rx_rp         <= '0;
        end else begin
            unique case (bus_st)
                B_IDLE: begin
                    if (accept) begin
                        bus_st        <= B_RESP;
                        bus.mem_ready <= 1'b1;
                        bus.mem_rdata <= rdata_nxt;
                    end
                end
                B_RESP: begin
                    bus_st        <= B_IDLE;
                    bus.mem_ready <= 1'b0;
                end
                default: bus_st <= B_IDLE;
            endcase
            if (tx_push)
                tx_wp <= tx_wp + 1'b1;
            if (rx_pop)
                rx_rp <= rx_rp + 1'b1;
        end
    end

    // Sticky flags: a set in the same cycle as a W1C clear wins.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_wp      <= '0;
            rx_overrun <= 1'b0;
            rx_error   <= 1'b0;
        end else begin
            if (rx_push)
                rx_wp <= rx_wp + 1'b1;
            rx_overrun <= set_ovr ||
                (rx_overrun && !(wr_ctrl && bus.mem_wdata[3]));
            rx_error <= recv_error ||
                (rx_error && !(wr_ctrl && bus.mem_wdata[4]));
        end
    end

    // After reset an in-flight core frame is left to finish:
    // IDLE only leaves once is_transmitting is low.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_st      <= T_IDLE;
            tx_trigger <= 1'b0;
            tx_byte    <= 8'd0;
            tx_rp      <= '0;
        end else begin
            unique case (tx_st)
                T_IDLE: begin
                    if (!tx_empty && !is_transmitting)
                        tx_st <= T_START;
                end
                T_START: begin
                    tx_byte    <= tx_mem[tx_rp[TW-1:0]];
                    tx_rp      <= tx_rp + 1'b1;
                    tx_trigger <= 1'b1;
                    tx_st      <= T_TRIG;
                end
                T_TRIG: begin
                    tx_trigger <= 1'b0;
                    tx_st      <= T_WBUSY;
                end
                T_WBUSY: begin
                    if (is_transmitting)
                        tx_st <= T_WDONE;
                end
                T_WDONE: begin
                    if (!is_transmitting)
                        tx_st <= T_IDLE;
                end
                default: tx_st <= T_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_controller.sv
// Bench for uart_controller: queue-based reference model,
// a fake uart core, directed scenarios and random traffic.
module tb_uart_controller;
    localparam int TXD = 16;
    localparam int RXD = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    uart_bus_if bus();
    logic       tx_trigger;
    logic [7:0] tx_byte;
    logic       received = 1'b0;
    logic [7:0] rx_byte = 8'd0;
    logic       is_transmitting = 1'b0;
    logic       recv_error = 1'b0;

    uart_controller #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus),
        .tx_trigger(tx_trigger),
        .tx_byte(tx_byte),
        .received(received),
        .rx_byte(rx_byte),
        .is_transmitting(is_transmitting),
        .recv_error(recv_error)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s timed out", name);
    endtask

    // Reference model: plain queues plus sticky bits.
    logic [7:0]  rx_q[$];
    logic [7:0]  tx_q[$];
    logic [7:0]  trig_log[$];
    bit          m_ovr = 0, m_err = 0, m_resp = 0;
    bit          exp_ready = 0, exp_read = 0;
    logic [31:0] exp_rdata = 32'd0;
    bit          mon_on = 0;
    int          trig_count = 0;

    task automatic model_step();
        bit is_wr, sel, pop, acc, cl_o, cl_e, set_o;
        logic [31:0] stat;
        if (!reset_n) begin
            rx_q.delete();
            tx_q.delete();
            m_ovr = 0; m_err = 0; m_resp = 0;
            exp_ready = 0; exp_read = 0; exp_rdata = 32'd0;
            return;
        end
        stat = {26'd0, is_transmitting, m_err, m_ovr,
                rx_q.size() != 0, tx_q.size() == 0, tx_q.size() == TXD};
        pop = 0; cl_o = 0; cl_e = 0; set_o = 0;
        if (m_resp) begin
            m_resp = 0;
            exp_ready = 0;
        end else if (bus.mem_valid) begin
            is_wr = bus.mem_wstrb != 4'd0;
            sel = bus.mem_addr[2];
            acc = 1;
            exp_read = !is_wr;
            if (is_wr && !sel) begin
                if (tx_q.size() < TXD) tx_q.push_back(bus.mem_wdata[7:0]);
                else acc = 0;
            end else if (!is_wr && !sel) begin
                if (rx_q.size() != 0) begin
                    exp_rdata = {24'd0, rx_q[0]};
                    pop = 1;
                end else exp_rdata = 32'hFFFF_FFFF;
            end else if (!is_wr) begin
                exp_rdata = stat;
            end else begin
                cl_o = bus.mem_wdata[3];
                cl_e = bus.mem_wdata[4];
            end
            if (acc) begin
                m_resp = 1;
                exp_ready = 1;
            end
        end
        if (received && !recv_error) begin
            if (rx_q.size() == RXD && !pop) set_o = 1;
            else rx_q.push_back(rx_byte);
        end
        if (pop) void'(rx_q.pop_front());
        m_ovr = set_o || (m_ovr && !cl_o);
        m_err = recv_error || (m_err && !cl_e);
    endtask

    task automatic compare();
        check("mem_ready", 32'(bus.mem_ready), 32'(exp_ready));
        if (exp_ready && exp_read)
            check("mem_rdata", bus.mem_rdata, exp_rdata);
        if (tx_trigger === 1'b1) begin
            trig_count++;
            trig_log.push_back(tx_byte);
            check("trig_while_busy", 32'(is_transmitting), 32'd0);
            if (tx_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL tx_spurious byte=%h expected no trigger",
                         tx_byte);
            end else begin
                check("tx_byte", 32'(tx_byte), 32'(tx_q.pop_front()));
            end
        end else begin
            check("tx_trigger", 32'(tx_trigger), 32'd0);
        end
    endtask

    always @(posedge clk) begin
        if (mon_on) begin
            model_step();
            #2;
            compare();
        end
    end

    // Fake uart core: busy for a few cycles after each trigger.
    int c_delay = 0, c_len = 0;
    bit hold_busy = 0, long_frame = 0;
    always @(posedge clk) begin
        #3;
        if (tx_trigger === 1'b1) begin
            c_delay = $urandom_range(0, 2);
            c_len = long_frame ? 50 : $urandom_range(2, 5);
        end else if (c_delay > 0) c_delay--;
        else if (c_len > 0) c_len--;
        is_transmitting = hold_busy || (c_delay == 0 && c_len > 0);
    end

    task automatic cpu(input bit sel, input bit wr,
                       input logic [31:0] wd, output logic [31:0] rd);
        int n;
        @(posedge clk); #1;
        bus.mem_valid = 1'b1;
        bus.mem_addr = sel ? 32'hF000_0004 : 32'hF000_0000;
        bus.mem_wstrb = wr ? 4'hF : 4'h0;
        bus.mem_wdata = wd;
        n = 0;
        do begin
            @(posedge clk); #2;
            n++;
        end while (!bus.mem_ready && n < 400);
        if (!bus.mem_ready) timeout("bus_access");
        rd = bus.mem_rdata;
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'h0;
    endtask

    task automatic rx_send(input logic [7:0] b, input bit err);
        @(posedge clk); #1;
        received = 1'b1;
        rx_byte = b;
        recv_error = err;
        @(posedge clk); #1;
        received = 1'b0;
        recv_error = 1'b0;
    endtask

    task automatic wait_tx_idle();
        int n = 0;
        while ((tx_q.size() != 0 || c_len != 0 || is_transmitting)
               && n < 2000) begin
            @(posedge clk); #2;
            n++;
        end
        if (n >= 2000) timeout("tx_idle");
        repeat (3) @(posedge clk);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog expired");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        logic [31:0] rd;
        int t0, base, nwr, n;
        bus.mem_valid = 1'b0;
        bus.mem_addr = 32'd0;
        bus.mem_wdata = 32'd0;
        bus.mem_wstrb = 4'd0;
        repeat (2) @(posedge clk);
        #1 mon_on = 1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        check("rst_ready", 32'(bus.mem_ready), 32'd0);
        check("rst_rdata", bus.mem_rdata, 32'd0);
        check("rst_trigger", 32'(tx_trigger), 32'd0);
        check("rst_tx_byte", 32'(tx_byte), 32'd0);
        cpu(1, 0, 0, rd);
        check("rst_status", rd, 32'h2);

        t0 = trig_count;
        cpu(0, 1, 32'h41, rd);
        wait_tx_idle();
        check("t1_trig_count", 32'(trig_count - t0), 32'd1);
        check("t1_byte", 32'(trig_log[trig_log.size() - 1]), 32'h41);
        cpu(1, 0, 0, rd);
        check("t1_status", rd, 32'h2);

        hold_busy = 1;
        repeat (2) @(posedge clk);
        t0 = trig_count;
        base = trig_log.size();
        for (int i = 0; i < 16; i++) cpu(0, 1, 32'(i), rd);
        cpu(1, 0, 0, rd);
        check("t2_status_full", rd, 32'h21);
        fork
            cpu(0, 1, 32'h10, rd);
            begin
                repeat (10) @(posedge clk);
                #2 check("t2_stall", 32'(bus.mem_ready), 32'd0);
                hold_busy = 0;
            end
        join
        wait_tx_idle();
        check("t2_trig_count", 32'(trig_count - t0), 32'd17);
        for (int i = 0; i < 17; i++)
            if (base + i < trig_log.size())
                check("t2_order", 32'(trig_log[base + i]), 32'(i));

        rx_send(8'h5A, 0);
        rx_send(8'hA5, 0);
        cpu(1, 0, 0, rd);
        check("t3_status_avail", rd, 32'h6);
        cpu(0, 0, 0, rd);
        check("t3_rd0", rd, 32'h5A);
        cpu(0, 0, 0, rd);
        check("t3_rd1", rd, 32'hA5);
        cpu(0, 0, 0, rd);
        check("t3_rd_empty", rd, 32'hFFFF_FFFF);
        cpu(1, 0, 0, rd);
        check("t3_status_empty", rd, 32'h2);

        for (int i = 0; i < 17; i++) rx_send(8'(8'h30 + i), 0);
        cpu(1, 0, 0, rd);
        check("t4_status_ovr", rd, 32'hE);
        cpu(1, 1, 32'h8, rd);
        cpu(1, 0, 0, rd);
        check("t4_status_clr", rd, 32'h6);
        for (int i = 0; i < 16; i++) begin
            cpu(0, 0, 0, rd);
            check("t4_data", rd, 32'(8'h30 + i));
        end
        cpu(0, 0, 0, rd);
        check("t4_empty", rd, 32'hFFFF_FFFF);
        rx_send(8'h77, 1);
        cpu(1, 0, 0, rd);
        check("t4_status_err", rd, 32'h12);
        cpu(0, 0, 0, rd);
        check("t4_err_nopush", rd, 32'hFFFF_FFFF);
        cpu(1, 1, 32'h10, rd);
        cpu(1, 0, 0, rd);
        check("t4_err_clr", rd, 32'h2);

        for (int i = 0; i < 16; i++) rx_send(8'(8'h80 + i), 0);
        fork
            cpu(0, 0, 0, rd);
            rx_send(8'hEE, 0);
        join
        check("t5_pop", rd, 32'h80);
        cpu(1, 0, 0, rd);
        check("t5_status", rd, 32'h6);
        for (int i = 1; i < 16; i++) begin
            cpu(0, 0, 0, rd);
            check("t5_data", rd, 32'(8'h80 + i));
        end
        cpu(0, 0, 0, rd);
        check("t5_last", rd, 32'hEE);
        cpu(0, 0, 0, rd);
        check("t5_empty", rd, 32'hFFFF_FFFF);

        long_frame = 1;
        t0 = trig_count;
        for (int i = 0; i < 4; i++) cpu(0, 1, 32'(8'hC0 + i), rd);
        n = 0;
        while (trig_count == t0 && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        if (n >= 100) timeout("t6_first_trigger");
        check("t6_pre_reset_trigs", 32'(trig_count - t0), 32'd1);
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        reset_n = 1'b1;
        check("t6_rst_trigger", 32'(tx_trigger), 32'd0);
        t0 = trig_count;
        cpu(1, 0, 0, rd);
        check("t6_status", rd, 32'h22);
        long_frame = 0;
        repeat (80) @(posedge clk);
        #2 check("t6_no_trigger", 32'(trig_count - t0), 32'd0);
        cpu(0, 0, 0, rd);
        check("t6_rx_empty", rd, 32'hFFFF_FFFF);

        t0 = trig_count;
        nwr = 0;
        fork
            begin
                repeat (150) begin
                    n = $urandom_range(0, 9);
                    if (n < 4) begin
                        cpu(0, 1, $urandom, rd);
                        nwr++;
                    end else if (n < 7) cpu(0, 0, 0, rd);
                    else if (n < 9) cpu(1, 0, 0, rd);
                    else cpu(1, 1, $urandom & 32'h18, rd);
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                end
            end
            begin
                repeat (700) begin
                    @(posedge clk); #1;
                    received = $urandom_range(0, 3) == 0;
                    rx_byte = 8'($urandom);
                    recv_error = $urandom_range(0, 39) == 0;
                end
                @(posedge clk); #1;
                received = 1'b0;
                recv_error = 1'b0;
            end
        join
        wait_tx_idle();
        check("rand_tx_total", 32'(trig_count - t0), 32'(nwr));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
